mult108_col_scheduler: RTL and testbench

- Sequences one 108x108 unsigned multiply through a shared row of four 27x18 DSP multiplier slices.
- Issues one 18-bit limb of b per cycle, six columns in total, against all four 27-bit limbs of a.
- Accumulates the returned 45-bit partial products into a 216-bit product.
- Sits between the modular-arithmetic front end and the DSP slice row, replacing the full 24-slice multiplier array with a 4-slice time-multiplexed one.

---
 rtl/mult108_col_scheduler_if.sv | 24 ++
 rtl/mult108_col_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_mult108_col_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult108_col_scheduler_if.sv
// Operand/product handshake and DSP slice-row bus for mult108_col_scheduler.
// The scheduler takes the slave side; front end plus slice row take the master side.
interface mult108_col_scheduler_if;
    logic         in_valid;
    logic         in_ready;
    logic [107:0] in_a;
    logic [107:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [215:0] out_prod;
    logic [107:0] dsp_a;
    logic [17:0]  dsp_b;
    logic [179:0] dsp_p;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, dsp_p,
        output in_ready, out_valid, out_prod, dsp_a, dsp_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, dsp_p,
        input  in_ready, out_valid, out_prod, dsp_a, dsp_b
    );
endinterface

// File: rtl/mult108_col_scheduler.sv
// 108x108 multiply time-multiplexed over four 27x18 DSP slices, one b limb per cycle.
// Define MULT_ZERO_SKIP_EN to skip columns whose b limb is zero.
module mult108_col_scheduler #(
    parameter int unsigned DSP_LAT = 3
) (
    input logic                    clk,
    input logic                    rst,
    mult108_col_scheduler_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e         state_q, state_d;
    logic [107:0]   a_q, a_d, b_q, b_d;
    logic [107:0]   dsp_a_q, dsp_a_d;
    logic [17:0]    dsp_b_q, dsp_b_d, b_col;
    logic [5:0]     mask_q, mask_d, in_mask, col_bit;
    logic [2:0]     col;
    logic [2:0]     issued_q, issued_d, returned_q, returned_d;
    logic [215:0]   acc_q, acc_d, prod_q, prod_d, addend;
    logic           issuing;
    logic           ret_vld;
    logic [2:0]     ret_col;
    logic [DSP_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [2:0]     tag_col_q [DSP_LAT];
    logic [2:0]     tag_col_d [DSP_LAT];

    // Columns still to issue; all six unless zero limbs are being skipped.
`ifdef MULT_ZERO_SKIP_EN
    always_comb begin
        in_mask = '0;
        for (int j = 0; j < 6; j++) begin
            in_mask[j] = |bus.in_b[18*j +: 18];
        end
    end
`else
    assign in_mask = '1;
`endif

    // Lowest pending column keeps issue order ascending.
    always_comb begin
        col     = '0;
        col_bit = '0;
        for (int j = 5; j >= 0; j--) begin
            if (mask_q[j]) begin
                col     = 3'(j);
                col_bit = 6'd1 << j;
            end
        end
    end

    always_comb begin
        case (col)
            3'd0:    b_col = b_q[17:0];
            3'd1:    b_col = b_q[35:18];
            3'd2:    b_col = b_q[53:36];
            3'd3:    b_col = b_q[71:54];
            3'd4:    b_col = b_q[89:72];
            3'd5:    b_col = b_q[107:90];
            default: b_col = '0;
        endcase
    end

    assign ret_vld = tag_vld_q[DSP_LAT-1];
    assign ret_col = tag_col_q[DSP_LAT-1];

    always_comb begin
        addend = '0;
        for (int r = 0; r < 4; r++) begin
            addend = addend + ({171'b0, bus.dsp_p[45*r +: 45]} << (27*r + 18*int'(ret_col)));
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        mask_d     = mask_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        dsp_a_d    = dsp_a_q;
        dsp_b_d    = dsp_b_q;
        issuing    = 1'b0;

        if (ret_vld) begin
            acc_d      = acc_q + addend;
            returned_d = returned_q + 3'd1;
        end

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d        = bus.in_a;
                    b_d        = bus.in_b;
                    acc_d      = '0;
                    issued_d   = '0;
                    returned_d = '0;
                    mask_d     = in_mask;
                    if (in_mask == '0) begin
                        prod_d  = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                issuing  = 1'b1;
                dsp_a_d  = a_q;
                dsp_b_d  = b_col;
                mask_d   = mask_q & ~col_bit;
                issued_d = issued_q + 3'd1;
                if (mask_d == '0) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Finish on the same edge the last column lands.
                if (returned_d == issued_q) begin
                    prod_d  = acc_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Tag travels alongside the operands so each returning dsp_p knows its column.
    always_comb begin
        tag_vld_d    = '0;
        tag_vld_d[0] = issuing;
        tag_col_d[0] = col;
        for (int i = 1; i < int'(DSP_LAT); i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_col_d[i] = tag_col_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            mask_q     <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            dsp_a_q    <= '0;
            dsp_b_q    <= '0;
            tag_vld_q  <= '0;
            tag_col_q  <= '{default: '0};
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mask_q     <= mask_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            dsp_a_q    <= dsp_a_d;
            dsp_b_q    <= dsp_b_d;
            tag_vld_q  <= tag_vld_d;
            tag_col_q  <= tag_col_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_prod  = prod_q;
    assign bus.dsp_a     = issuing ? a_q : dsp_a_q;
    assign bus.dsp_b     = issuing ? b_col : dsp_b_q;
endmodule

// File: tb/tb_mult108_col_scheduler.sv
// Directed + random bench for mult108_col_scheduler with a latency-matched DSP slice row model.
// Expected products are queued at acceptance and checked at the output handshake.
module tb_mult108_col_scheduler;
    localparam int unsigned DSP_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [215:0] sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult108_col_scheduler_if bus ();

    mult108_col_scheduler #(.DSP_LAT(DSP_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Slice row: p_r = a_r * b, DSP_LAT register stages.
    function automatic logic [179:0] slice_row(input logic [107:0] a, input logic [17:0] b);
        logic [179:0] p;
        for (int r = 0; r < 4; r++) begin
            p[45*r +: 45] = {18'b0, a[27*r +: 27]} * {27'b0, b};
        end
        return p;
    endfunction

    logic [179:0] p_pipe [DSP_LAT];
    always @(posedge clk) begin
        p_pipe[0] <= slice_row(bus.dsp_a, bus.dsp_b);
        for (int i = 1; i < int'(DSP_LAT); i++) p_pipe[i] <= p_pipe[i-1];
    end
    assign bus.dsp_p = p_pipe[DSP_LAT-1];

    function automatic logic [215:0] ref_mul(input logic [107:0] a, input logic [107:0] b);
        logic [215:0] x, y;
        x = {108'b0, a};
        y = {108'b0, b};
        return x * y;
    endfunction

    // Cycles from acceptance to first out_valid.
    function automatic int exp_lat(input logic [107:0] b);
        int k;
        k = 6;
`ifdef MULT_ZERO_SKIP_EN
        k = 0;
        for (int j = 0; j < 6; j++) if (b[18*j +: 18] != 18'd0) k++;
`endif
        return (k == 0) ? 1 : 1 + k + int'(DSP_LAT);
    endfunction

    task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) sb.push_back(ref_mul(bus.in_a, bus.in_b));
            if (bus.out_valid && bus.out_ready) begin
                logic [215:0] e;
                e = 'x;
                if (sb.size() != 0) e = sb.pop_front();
                chk("product", bus.out_prod, e);
            end
        end
    end

    // Waits for out_valid (bounded), checks latency, returns after the handshake edge.
    task automatic finish_mult(input int t0, input int lat, input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                chk({tag, "_latency"}, 216'(cyc - t0), 216'(lat));
            end
            tick();
        end
        chk({tag, "_complete"}, 216'(ok), 216'(1));
    endtask

    task automatic do_mult(input logic [107:0] a, input logic [107:0] b);
        bit ok;
        int t0;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        ok = 1'b0;
        t0 = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                t0 = cyc;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("accept", 216'(ok), 216'(1));
        finish_mult(t0, exp_lat(b), "mult");
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [215:0] e;
        logic [127:0] t;
        logic [107:0] ra, rb;
        logic [107:0] av [4];
        logic [107:0] bv [4];
        int t0, lat, prev;
        bit ok;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", 216'(bus.in_ready), 216'(1));
        chk("rst_out_valid", 216'(bus.out_valid), 216'(0));
        chk("rst_out_prod", bus.out_prod, 216'(0));
        chk("rst_dsp_a", 216'(bus.dsp_a), 216'(0));
        chk("rst_dsp_b", 216'(bus.dsp_b), 216'(0));
        tick();
        rst = 1'b0;

        // 1 x 1 with exact cycle profile
        tick();
        bus.in_a      = 108'd1;
        bus.in_b      = 108'd1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        lat = exp_lat(108'd1);
        @(negedge clk);
        chk("t1_ready_c0", 216'(bus.in_ready), 216'(1));
        tick();
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("t1_out_valid", 216'(bus.out_valid), 216'(c == lat));
            chk("t1_in_ready", 216'(bus.in_ready), 216'(c > lat));
            if (c == 1) begin
                chk("t1_dsp_b_c1", 216'(bus.dsp_b), 216'(1));
                chk("t1_dsp_a_c1", 216'(bus.dsp_a), 216'(1));
            end
            tick();
        end

        // Max operands
        do_mult('1, '1);
        e = '0;
        e = e - (216'd1 << 109) + 216'd1;
        chk("t2_max_prod", bus.out_prod, e);

        // Random operands, some with zeroed limbs
        for (int n = 0; n < 1000; n++) begin
            t  = {$urandom(), $urandom(), $urandom(), $urandom()};
            ra = t[107:0];
            t  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rb = t[107:0];
            if ($urandom_range(0, 3) == 0) rb[18*$urandom_range(0, 5) +: 18] = '0;
            if ($urandom_range(0, 7) == 0) ra[27*$urandom_range(0, 3) +: 27] = '0;
            do_mult(ra, rb);
        end

        // Output backpressure
        ra = 108'h123456789;
        rb = (108'd1 << 90) + 108'd5;
        e  = ref_mul(ra, rb);
        bus.in_a      = ra;
        bus.in_b      = rb;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        tick();
        bus.in_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1'b1;
            else begin
                chk("t3_busy_ready", 216'(bus.in_ready), 216'(0));
                tick();
            end
        end
        chk("t3_complete", 216'(ok), 216'(1));
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", 216'(bus.out_valid), 216'(1));
            chk("t3_hold_ready", 216'(bus.in_ready), 216'(0));
            chk("t3_hold_prod", bus.out_prod, e);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t3_after_ready", 216'(bus.in_ready), 216'(1));
        chk("t3_after_valid", 216'(bus.out_valid), 216'(0));
        tick();

        // Back-to-back with in_valid held high and busy-time operand churn
        av[0] = 108'hF_FFFF_0000_1234_5678_9ABC_DEF0;
        bv[0] = 108'h1_2345_6789_ABCD_EF01_2345_6789;
        av[1] = 108'd12345;
        bv[1] = '1;
        av[2] = '1;
        bv[2] = 108'h0_0000_0000_0000_0000_0003_FFFF;
        av[3] = 108'h8_0000_0000_0000_0000_0000_0001;
        bv[3] = 108'h8_0000_0000_0000_0000_0000_0001;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        prev = 0;
        for (int p = 0; p < 4; p++) begin
            bus.in_a = av[p];
            bus.in_b = bv[p];
            ok = 1'b0;
            t0 = 0;
            for (int k = 0; k < 40 && !ok; k++) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    ok = 1'b1;
                    t0 = cyc;
                end
                tick();
            end
            chk("t4_accept", 216'(ok), 216'(1));
            if (p > 0) chk("t4_spacing", 216'(t0 - prev), 216'(exp_lat(bv[p-1]) + 1));
            prev = t0;
            if (p == 3) bus.in_valid = 1'b0;
            bus.in_a = ~av[p];
            bus.in_b = ~bv[p];
            tick();
            tick();
            tick();
        end
        finish_mult(prev, exp_lat(bv[3]), "t4_last");
        chk("t4_sb_empty", 216'(sb.size()), 216'(0));

        // Reset in cycle 3 of a multiply, then a clean 3 x 7
        bus.in_a     = 108'h7_7777_7777_7777_7777_7777_7777;
        bus.in_b     = 108'h5_5555_5555_5555_5555_5555_5555;
        bus.in_valid = 1'b1;
        @(negedge clk);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_in_ready", 216'(bus.in_ready), 216'(1));
        chk("t5_out_valid", 216'(bus.out_valid), 216'(0));
        chk("t5_out_prod_rst", bus.out_prod, 216'(0));
        tick();
        do_mult(108'd3, 108'd7);
        chk("t5_prod", bus.out_prod, 216'(21));

`ifdef MULT_ZERO_SKIP_EN
        // Single nonzero limb, then b == 0
        bus.in_a      = 108'hABC_DEF0_1234;
        bus.in_b      = 108'd1 << 90;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        t0 = cyc;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("zs_dsp_b", 216'(bus.dsp_b), 216'(1));
        finish_mult(t0, 1 + 1 + int'(DSP_LAT), "zs_one");
        do_mult(108'hABC_DEF0_1234, '0);
        chk("zs_zero_prod", bus.out_prod, 216'(0));
        chk("zs_dsp_b_hold", 216'(bus.dsp_b), 216'(1));
`endif

        tick();
        chk("sb_drained", 216'(sb.size()), 216'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
